// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and helpers for the OPB software register bank.
package opb_regbank_pkg;

  // Bus-slave handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } slv_state_e;

  // CTRL bit that triggers copying every shadow to the outputs.
  localparam int unsigned CTRL_COMMIT_BIT = 0;

  // Byte-masked update: be[b]=1 takes byte b from new_v, otherwise keeps old_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side signal bundle; bit 0 is the MSB, as on the OPB.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink_slave.sv
// OPB slave handshake: address decode, request capture and the IDLE/ACK/WAIT FSM.
// Emits a read strobe with the live word index when a read is accepted, and a
// write strobe with the captured request during the ack cycle.
module opb_slave_if
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100E400,
  parameter logic [31:0] C_HIGHADDR = 32'h0100E4FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] abus_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] dbus_i,
  input  logic        rnw_i,
  input  logic        select_i,
  output logic        ack_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic [29:0] idx_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);

  slv_state_e  state_q, state_d;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rnw_q;
  logic        hit_s;
  logic        accept_s;
  logic [31:0] off_s;
  logic        unused_s;

  assign hit_s    = (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
  assign off_s    = abus_i - C_BASEADDR;
  assign accept_s = (state_q == IDLE) && select_i && hit_s;
  assign unused_s = ^off_s[1:0];
  assign wdata_o  = wdata_q;
  assign be_o     = be_q;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the request on the edge that accepts it; the write uses these values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= 30'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rnw_q   <= 1'b1;
    end else if (accept_s) begin
      idx_q   <= off_s[31:2];
      wdata_q <= dbus_i;
      be_q    <= be_i;
      rnw_q   <= rnw_i;
    end else begin
      idx_q   <= idx_q;
      wdata_q <= wdata_q;
      be_q    <= be_q;
      rnw_q   <= rnw_q;
    end
  end

  // Next state: one ack per select, then wait for select to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = ACK; else state_d = IDLE;
      ACK:     state_d = WAIT;
      WAIT:    if (!select_i) state_d = IDLE; else state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and word index derived from the current state.
  always_comb begin
    ack_o   = 1'b0;
    wr_en_o = 1'b0;
    rd_en_o = 1'b0;
    idx_o   = idx_q;
    case (state_q)
      IDLE: begin
        rd_en_o = accept_s && rnw_i;
        idx_o   = off_s[31:2];
      end
      ACK: begin
        ack_o   = 1'b1;
        wr_en_o = !rnw_q;
      end
      WAIT:    ack_o = 1'b0;
      default: ack_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of N_REGS PPC-writable registers feeding user logic, with byte-enable
// writes, readback, optional auto-clear per register and optional atomic commit.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E4FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned N_REGS       = 4,
  parameter logic [31:0] PULSE_MASK   = 32'h0,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter bit          SHADOW_MODE  = 1'b0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [N_REGS*32-1:0]    user_data_out,
  output logic [N_REGS-1:0]       user_data_valid
);

  if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_width_check
    $error("opb_register_bank_ppc2simulink supports only a 32-bit OPB");
  end

  localparam logic [29:0] CTRL_IDX = 30'(N_REGS);
  localparam logic [31:0] CTRL_VAL = {16'h0, 8'(N_REGS), 7'h0, SHADOW_MODE};

  logic [31:0]       shadow_q [N_REGS];
  logic [31:0]       shadow_d [N_REGS];
  logic [31:0]       out_q    [N_REGS];
  logic [31:0]       out_d    [N_REGS];
  logic [N_REGS-1:0] valid_q, valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_s, wr_en_s, rd_en_s, commit_s;
  logic [29:0]       idx_s;
  logic [31:0]       wdata_s;
  logic [3:0]        be_s;
  logic [31:0]       abus_s, dbus_s;
  logic [3:0]        opb_be_s;
  logic              unused_s;

  // OPB bit 0 is the MSB, so plain assignment maps DBus[0:7] onto bits 31:24.
  assign abus_s   = opb.OPB_ABus;
  assign dbus_s   = opb.OPB_DBus;
  assign opb_be_s = opb.OPB_BE;
  assign unused_s = opb.OPB_seqAddr;

  opb_slave_if #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_slave (
    .clk_i    (OPB_Clk),
    .rst_i    (OPB_Rst),
    .abus_i   (abus_s),
    .be_i     (opb_be_s),
    .dbus_i   (dbus_s),
    .rnw_i    (opb.OPB_RNW),
    .select_i (opb.OPB_select),
    .ack_o    (ack_s),
    .wr_en_o  (wr_en_s),
    .rd_en_o  (rd_en_s),
    .idx_o    (idx_s),
    .wdata_o  (wdata_s),
    .be_o     (be_s)
  );

  // Register updates: auto-clear of pulse regs, byte-masked writes and commit.
  always_comb begin
    valid_d  = {N_REGS{1'b0}};
    commit_s = wr_en_s && (idx_s == CTRL_IDX) && wdata_s[CTRL_COMMIT_BIT]
               && (SHADOW_MODE == 1'b1);
    for (int i = 0; i < N_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      out_d[i]    = out_q[i];
      if (PULSE_MASK[i] && valid_q[i]) begin
        shadow_d[i] = 32'h0;
        out_d[i]    = 32'h0;
      end else if (wr_en_s && (idx_s == 30'(i))) begin
        shadow_d[i] = be_merge(shadow_q[i], wdata_s, be_s);
        if (SHADOW_MODE == 1'b0) begin
          out_d[i]   = be_merge(shadow_q[i], wdata_s, be_s);
          valid_d[i] = 1'b1;
        end else begin
          out_d[i] = out_q[i];
        end
      end else if (commit_s) begin
        out_d[i]   = shadow_q[i];
        valid_d[i] = 1'b1;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  // Readback mux, loaded only when a read is accepted so the bus sees zero otherwise.
  always_comb begin
    rdata_d = 32'h0;
    if (rd_en_s) begin
      rdata_d = (idx_s == CTRL_IDX) ? CTRL_VAL : 32'h0;
      for (int i = 0; i < N_REGS; i++) begin
        rdata_d = (idx_s == 30'(i)) ? shadow_q[i] : rdata_d;
      end
    end else begin
      rdata_d = 32'h0;
    end
  end

  // Register bank, output strobes and read data.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= RESET_VALUE;
        out_q[i]    <= RESET_VALUE;
      end
      valid_q <= {N_REGS{1'b0}};
      rdata_q <= 32'h0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        out_q[i]    <= out_d[i];
      end
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = out_q[g];
  end
  assign user_data_valid = valid_q;

  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_xferAck = ack_s;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Two banks on one OPB: A (E400, direct mode, reg0 pulsed) and B (E500, commit mode).
module tb_opb_register_bank_ppc2simulink;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] abus, dbus;
  logic [3:0]  be;
  logic        rnw, sel;

  opb_register_bank_ppc2simulink_if ifa ();
  opb_register_bank_ppc2simulink_if ifb ();

  assign ifa.OPB_ABus = abus;  assign ifb.OPB_ABus = abus;
  assign ifa.OPB_DBus = dbus;  assign ifb.OPB_DBus = dbus;
  assign ifa.OPB_BE = be;      assign ifb.OPB_BE = be;
  assign ifa.OPB_RNW = rnw;    assign ifb.OPB_RNW = rnw;
  assign ifa.OPB_select = sel; assign ifb.OPB_select = sel;
  assign ifa.OPB_seqAddr = 1'b0;
  assign ifb.OPB_seqAddr = 1'b0;

  logic [127:0] out_a, out_b;
  logic [3:0]   val_a, val_b;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(32'h0100E400), .C_HIGHADDR(32'h0100E4FF), .N_REGS(4),
    .PULSE_MASK(32'h1), .RESET_VALUE(32'h0), .SHADOW_MODE(1'b0)
  ) dut_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(ifa),
    .user_data_out(out_a), .user_data_valid(val_a)
  );

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(32'h0100E500), .C_HIGHADDR(32'h0100E5FF), .N_REGS(4),
    .PULSE_MASK(32'h0), .RESET_VALUE(32'h0), .SHADOW_MODE(1'b1)
  ) dut_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(ifb),
    .user_data_out(out_b), .user_data_valid(val_b)
  );

  typedef struct {
    logic        dut;   // 0 = bank A, 1 = bank B
    logic [31:0] data;  // Sl_DBus expected in the ack cycle
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response; with no ack both buses must read zero.
  exp_t        m_e;
  string       m_nm;
  logic [31:0] m_d;
  always @(negedge clk) begin
    if (ifa.Sl_xferAck === 1'b1 || ifb.Sl_xferAck === 1'b1) begin
      n_vec++;
      m_d = (ifa.Sl_xferAck === 1'b1) ? ifa.Sl_DBus : ifb.Sl_DBus;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: ack_a=%b ack_b=%b dbus=%h expected no ack",
                 ifa.Sl_xferAck, ifb.Sl_xferAck, m_d);
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        if (ifa.Sl_xferAck === ifb.Sl_xferAck || ifb.Sl_xferAck !== m_e.dut || m_d !== m_e.data) begin
          n_err++;
          $display("FAIL %s: ack_a=%b ack_b=%b dbus=%h expected bank=%0d dbus=%h",
                   m_nm, ifa.Sl_xferAck, ifb.Sl_xferAck, m_d, m_e.dut, m_e.data);
        end
      end
    end else begin
      n_vec++;
      if (ifa.Sl_DBus !== 32'h0 || ifb.Sl_DBus !== 32'h0) begin
        n_err++;
        $display("FAIL idle_dbus: a=%h b=%h expected 00000000", ifa.Sl_DBus, ifb.Sl_DBus);
      end
    end
  end

  // One OPB transfer; hold keeps select asserted for extra cycles after the ack.
  task automatic xfer(input logic bank, input logic [31:0] addr, input logic rd,
                      input logic [31:0] wd, input logic [3:0] bev, input logic [31:0] exp_rd,
                      input bit exp_ack, input int hold, input string nm);
    int   lat;
    int   acks;
    exp_t e;
    if (exp_ack) begin
      e.dut  = bank;
      e.data = rd ? exp_rd : 32'h0;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    abus = addr; dbus = wd; be = bev; rnw = rd; sel = 1'b1;
    lat  = -1;
    acks = 0;
    for (int k = 0; k < 6 + hold; k++) begin
      @(negedge clk);
      if (ifa.Sl_xferAck === 1'b1 || ifb.Sl_xferAck === 1'b1) begin
        acks++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + hold) break;
    end
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b1; abus = 32'h0; dbus = 32'h0; be = 4'h0;
    if (exp_ack) begin
      chk({nm, "_latency"}, 128'(lat), 128'd1);
      if (hold > 0) chk({nm, "_ack_count"}, 128'(acks), 128'd1);
    end else begin
      chk({nm, "_no_ack"}, 128'(acks), 128'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; abus = 32'h0; dbus = 32'h0; be = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_a", out_a, 128'h0);
    chk("reset_out_b", out_b, 128'h0);
    chk("reset_valid", {val_a, val_b}, 128'h0);
    chk("reset_ack", {ifa.Sl_xferAck, ifb.Sl_xferAck}, 128'h0);

    // Direct mode full-word write to reg2.
    xfer(1'b0, 32'h0100E408, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 0, "wr_a2");
    @(negedge clk);
    chk("a2_out", out_a[95:64], 128'hDEADBEEF);
    chk("a2_valid", val_a, 128'h4);
    @(negedge clk);
    chk("a2_valid_end", val_a, 128'h0);

    // Byte-enable write (DBus[24:31] -> bits 7:0) and readback.
    xfer(1'b0, 32'h0100E408, 1'b0, 32'h000000AA, 4'b0001, 32'h0, 1'b1, 0, "wr_a2_be");
    @(negedge clk);
    chk("a2_be_out", out_a, {32'h0, 32'hDEADBEAA, 32'h0, 32'h0});
    xfer(1'b0, 32'h0100E408, 1'b1, 32'h0, 4'hF, 32'hDEADBEAA, 1'b1, 0, "rd_a2");

    // CTRL write in direct mode does nothing; CTRL read reports size and mode.
    xfer(1'b0, 32'h0100E410, 1'b0, 32'h00000001, 4'hF, 32'h0, 1'b1, 0, "wr_a_ctrl");
    @(negedge clk);
    chk("a_ctrl_ignored", {val_a, out_a}, {4'h0, 32'h0, 32'hDEADBEAA, 32'h0, 32'h0});
    xfer(1'b0, 32'h0100E410, 1'b1, 32'h0, 4'hF, 32'h00000400, 1'b1, 0, "rd_a_ctrl");

    // Pulse register: value lasts exactly one cycle.
    xfer(1'b0, 32'h0100E400, 1'b0, 32'h00000005, 4'hF, 32'h0, 1'b1, 0, "wr_a0_pulse");
    @(negedge clk);
    chk("a0_pulse_hi", {val_a, out_a[31:0]}, {4'b0001, 32'h5});
    @(negedge clk);
    chk("a0_pulse_lo", {val_a, out_a[31:0]}, {4'b0000, 32'h0});
    xfer(1'b0, 32'h0100E400, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 0, "rd_a0_pulse");

    // Long select gives one ack; unmapped in range acks with 0; out of range never acks.
    xfer(1'b0, 32'h0100E408, 1'b1, 32'h0, 4'hF, 32'hDEADBEAA, 1'b1, 5, "rd_a2_hold");
    xfer(1'b0, 32'h0100E4F0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 0, "rd_a_unmapped");
    xfer(1'b0, 32'h0100E600, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0, "rd_above_high");
    xfer(1'b0, 32'h0100E3FC, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0, "rd_below_base");

    // Commit mode: writes reach the shadow only until CTRL commit.
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 32'h0100E500 + 32'(4 * i), 1'b0, 32'(i + 1), 4'hF, 32'h0, 1'b1, 0, "wr_b_shadow");
      @(negedge clk);
      chk("b_no_update", {val_b, out_b}, 132'h0);
    end
    xfer(1'b1, 32'h0100E508, 1'b1, 32'h0, 4'hF, 32'h00000003, 1'b1, 0, "rd_b2_shadow");
    xfer(1'b1, 32'h0100E510, 1'b0, 32'h00000001, 4'hF, 32'h0, 1'b1, 0, "wr_b_commit");
    @(negedge clk);
    chk("b_commit_out", out_b, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("b_commit_valid", val_b, 128'hF);
    @(negedge clk);
    chk("b_commit_valid_end", {val_b, out_b}, {4'h0, 32'd4, 32'd3, 32'd2, 32'd1});
    xfer(1'b1, 32'h0100E510, 1'b1, 32'h0, 4'hF, 32'h00000401, 1'b1, 0, "rd_b_ctrl");

    // Reset during the ack cycle drops the write and returns to idle.
    e.dut  = 1'b0;
    e.data = 32'h0;
    exp_q.push_back(e);
    name_q.push_back("wr_a1_rst");
    @(posedge clk); #1;
    abus = 32'h0100E404; dbus = 32'h12345678; be = 4'hF; rnw = 1'b0; sel = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ack_cycle", ifa.Sl_xferAck, 128'h1);
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0; rnw = 1'b1; abus = 32'h0; dbus = 32'h0; be = 4'h0;
    @(negedge clk);
    chk("rst_ack_low", ifa.Sl_xferAck, 128'h0);
    chk("rst_outputs", {out_a, out_b}, 256'h0);
    chk("rst_valid", {val_a, val_b}, 128'h0);
    xfer(1'b0, 32'h0100E408, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 0, "rd_a2_after_rst");
    xfer(1'b0, 32'h0100E40C, 1'b0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 0, "wr_a3_after_rst");
    @(negedge clk);
    chk("a3_out", {val_a, out_a}, {4'b1000, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0});
    xfer(1'b0, 32'h0100E40C, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 0, "rd_a3");

    repeat (2) @(negedge clk);
    chk("pending_acks", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
